// File: rtl/candy_stage_ctrl.sv
// Stage sequencer for the candy core: IF/ID/EX/MEM/WB handshake FSM with pc ownership,
// branch redirect, halt, fetch/memory watchdog and retired-instruction counter.
module candy_stage_ctrl #(
    parameter int unsigned ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned PC_STEP  = 1,
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              halt_req,
    output logic              if_en,
    input  logic              if_done,
    output logic              id_en,
    input  logic              inst_is_mem,
    input  logic              inst_is_halt,
    output logic              ex_en,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              mem_en,
    input  logic              mem_done,
    output logic              wb_en,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              halted,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  retired
);

    // state | meaning
    // IDLE  | parked, waiting for run
    // IF    | fetch, waits on if_done (watchdog)
    // ID    | decode, samples mem/halt flags
    // EX    | execute, resolves next_pc
    // MEM   | memory access, waits on mem_done (watchdog)
    // WB    | writeback, commits pc and retired
    // HALT  | stopped until rst
    // ERR   | watchdog fired, stopped until rst
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_IF = 3'd1, S_ID = 3'd2, S_EX = 3'd3,
        S_MEM  = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_ERR = 3'd7
    } state_t;

    localparam int unsigned WAIT_W      = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
    localparam int unsigned WAIT_LAST_I = (WAIT_MAX > 0) ? WAIT_MAX - 1 : 0;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_LAST_I[WAIT_W-1:0];
    localparam logic [ADDR_W-1:0] PC_INC    = ADDR_W'(PC_STEP);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d, next_pc_q, next_pc_d;
    logic                mem_flag_q, mem_flag_d;
    logic                halt_pend_q, halt_pend_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic                halted_q, halted_d, timeout_err_q, timeout_err_d;
    logic [4:0]          en_q, en_d;
    logic                halt_now, wd_expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            next_pc_q     <= RESET_PC;
            mem_flag_q    <= 1'b0;
            halt_pend_q   <= 1'b0;
            wait_cnt_q    <= '0;
            retired_q     <= '0;
            halted_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            en_q          <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            next_pc_q     <= next_pc_d;
            mem_flag_q    <= mem_flag_d;
            halt_pend_q   <= halt_pend_d;
            wait_cnt_q    <= wait_cnt_d;
            retired_q     <= retired_d;
            halted_q      <= halted_d;
            timeout_err_q <= timeout_err_d;
            en_q          <= en_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        next_pc_d   = next_pc_q;
        mem_flag_d  = mem_flag_q;
        retired_d   = retired_q;
        wait_cnt_d  = wait_cnt_q;
        halt_now    = halt_pend_q | halt_req;
        halt_pend_d = halt_now;
        // done in the expiry cycle still wins because it is tested first
        wd_expired  = (WAIT_MAX > 0) && (wait_cnt_q == WAIT_LAST);
        case (state_q)
            S_IDLE: begin
                if (halt_now)  state_d = S_HALT;
                else if (run)  state_d = S_IF;
            end
            S_IF: begin
                if (if_done)         state_d = S_ID;
                else if (wd_expired) state_d = S_ERR;
                else                 wait_cnt_d = wait_cnt_q + 1'b1;
            end
            S_ID: begin
                mem_flag_d = inst_is_mem;
                state_d    = inst_is_halt ? S_HALT : S_EX;
            end
            S_EX: begin
                next_pc_d = br_taken ? br_target : pc_q + PC_INC;
                state_d   = mem_flag_q ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (mem_done)        state_d = S_WB;
                else if (wd_expired) state_d = S_ERR;
                else                 wait_cnt_d = wait_cnt_q + 1'b1;
            end
            S_WB: begin
                pc_d      = next_pc_q;
                retired_d = retired_q + 1'b1;
                if (halt_now)  state_d = S_HALT;
                else if (run)  state_d = S_IF;
                else           state_d = S_IDLE;
            end
            default: state_d = state_q;
        endcase
        if (state_d != state_q) wait_cnt_d = '0;
    end

    // Enables pulse only on entry into their state.
    always_comb begin
        en_d[4]       = (state_d == S_IF)  && (state_q != S_IF);
        en_d[3]       = (state_d == S_ID)  && (state_q != S_ID);
        en_d[2]       = (state_d == S_EX)  && (state_q != S_EX);
        en_d[1]       = (state_d == S_MEM) && (state_q != S_MEM);
        en_d[0]       = (state_d == S_WB)  && (state_q != S_WB);
        halted_d      = halted_q | (state_d == S_HALT);
        timeout_err_d = timeout_err_q | (state_d == S_ERR);
    end

    assign {if_en, id_en, ex_en, mem_en, wb_en} = en_q;
    assign pc          = pc_q;
    assign state       = state_q;
    assign halted      = halted_q;
    assign timeout_err = timeout_err_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_candy_stage_ctrl.sv
// Self-checking bench for candy_stage_ctrl: per-cycle vector table through a scoreboard
// queue, then randomized IF/MEM wait lengths checked at each instruction boundary.
module tb_candy_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst, run, halt_req, if_done, inst_is_mem, inst_is_halt, br_taken, mem_done;
    logic [15:0] br_target;
    logic        if_en, id_en, ex_en, mem_en, wb_en, halted, timeout_err;
    logic [15:0] pc;
    logic [2:0]  state;
    logic [31:0] retired;

    candy_stage_ctrl #(
        .ADDR_W(16), .RESET_PC(16'h0000), .PC_STEP(1), .WAIT_MAX(4), .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .halt_req(halt_req),
        .if_en(if_en), .if_done(if_done), .id_en(id_en),
        .inst_is_mem(inst_is_mem), .inst_is_halt(inst_is_halt),
        .ex_en(ex_en), .br_taken(br_taken), .br_target(br_target),
        .mem_en(mem_en), .mem_done(mem_done), .wb_en(wb_en),
        .pc(pc), .state(state), .halted(halted), .timeout_err(timeout_err),
        .retired(retired)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] E_NO = 5'b00000, E_IF = 5'b10000, E_ID = 5'b01000,
                           E_EX = 5'b00100, E_MM = 5'b00010, E_WB = 5'b00001;

    // ctl = {rst, run, halt_req, if_done, inst_is_mem, inst_is_halt, br_taken, mem_done}
    typedef struct {
        logic [7:0]  ctl;
        logic [15:0] bra;
        logic [2:0]  st;
        logic [4:0]  en;
        logic [15:0] pc;
        logic [31:0] ret;
        logic [1:0]  fl;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic [7:0] ctl, input logic [15:0] bra, input logic [2:0] st,
                       input logic [4:0] en, input logic [15:0] p, input logic [31:0] ret,
                       input logic [1:0] fl);
        vec_t v;
        v.ctl = ctl; v.bra = bra; v.st = st; v.en = en; v.pc = p; v.ret = ret; v.fl = fl;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string tag, input vec_t e);
        chk({tag, " state"},   32'(state), 32'(e.st));
        chk({tag, " enables"}, 32'({if_en, id_en, ex_en, mem_en, wb_en}), 32'(e.en));
        chk({tag, " pc"},      32'(pc), 32'(e.pc));
        chk({tag, " retired"}, retired, e.ret);
        chk({tag, " flags"},   32'({halted, timeout_err}), 32'(e.fl));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        vec_t e;
        int d_if, d_mem, m;
        logic [15:0] exp_pc;

        {rst, run, halt_req, if_done, inst_is_mem, inst_is_halt, br_taken, mem_done} = 8'h80;
        br_target = 16'h0;

        // reset, then two sequential non-mem instructions
        add(8'b1000_0000, 16'h0,    3'd0, E_NO, 16'h0000, 32'd0, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd1, E_IF, 16'h0000, 32'd0, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd2, E_ID, 16'h0000, 32'd0, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd3, E_EX, 16'h0000, 32'd0, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd5, E_WB, 16'h0000, 32'd0, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd1, E_IF, 16'h0001, 32'd1, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd2, E_ID, 16'h0001, 32'd1, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd3, E_EX, 16'h0001, 32'd1, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd5, E_WB, 16'h0001, 32'd1, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd1, E_IF, 16'h0002, 32'd2, 2'b00);
        // mem instruction, mem_done in the 4th MEM cycle (last accepted with WAIT_MAX=4)
        add(8'b0101_0000, 16'h0,    3'd2, E_ID, 16'h0002, 32'd2, 2'b00);
        add(8'b0101_1000, 16'h0,    3'd3, E_EX, 16'h0002, 32'd2, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd4, E_MM, 16'h0002, 32'd2, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd4, E_NO, 16'h0002, 32'd2, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd4, E_NO, 16'h0002, 32'd2, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd4, E_NO, 16'h0002, 32'd2, 2'b00);
        add(8'b0101_0001, 16'h0,    3'd5, E_WB, 16'h0002, 32'd2, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd1, E_IF, 16'h0003, 32'd3, 2'b00);
        // branch to 0x0040, then to 0xFFFF, then sequential wrap to 0
        add(8'b0101_0000, 16'h0,    3'd2, E_ID, 16'h0003, 32'd3, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd3, E_EX, 16'h0003, 32'd3, 2'b00);
        add(8'b0101_0010, 16'h0040, 3'd5, E_WB, 16'h0003, 32'd3, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd1, E_IF, 16'h0040, 32'd4, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd2, E_ID, 16'h0040, 32'd4, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd3, E_EX, 16'h0040, 32'd4, 2'b00);
        add(8'b0101_0010, 16'hFFFF, 3'd5, E_WB, 16'h0040, 32'd4, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd1, E_IF, 16'hFFFF, 32'd5, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd2, E_ID, 16'hFFFF, 32'd5, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd3, E_EX, 16'hFFFF, 32'd5, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd5, E_WB, 16'hFFFF, 32'd5, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd1, E_IF, 16'h0000, 32'd6, 2'b00);
        // halt_req pulsed in MEM: instruction completes, then HALT
        add(8'b0101_0000, 16'h0,    3'd2, E_ID, 16'h0000, 32'd6, 2'b00);
        add(8'b0101_1000, 16'h0,    3'd3, E_EX, 16'h0000, 32'd6, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd4, E_MM, 16'h0000, 32'd6, 2'b00);
        add(8'b0111_0000, 16'h0,    3'd4, E_NO, 16'h0000, 32'd6, 2'b00);
        add(8'b0101_0001, 16'h0,    3'd5, E_WB, 16'h0000, 32'd6, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd6, E_NO, 16'h0001, 32'd7, 2'b10);
        add(8'b0101_0000, 16'h0,    3'd6, E_NO, 16'h0001, 32'd7, 2'b10);
        // halt instruction in ID: no pc/retired change
        add(8'b1000_0000, 16'h0,    3'd0, E_NO, 16'h0000, 32'd0, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd1, E_IF, 16'h0000, 32'd0, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd2, E_ID, 16'h0000, 32'd0, 2'b00);
        add(8'b0101_0100, 16'h0,    3'd6, E_NO, 16'h0000, 32'd0, 2'b10);
        add(8'b0101_0000, 16'h0,    3'd6, E_NO, 16'h0000, 32'd0, 2'b10);
        // watchdog: no if_done -> ERR on 5th cycle after IF entry
        add(8'b1000_0000, 16'h0,    3'd0, E_NO, 16'h0000, 32'd0, 2'b00);
        add(8'b0100_0000, 16'h0,    3'd1, E_IF, 16'h0000, 32'd0, 2'b00);
        add(8'b0100_0000, 16'h0,    3'd1, E_NO, 16'h0000, 32'd0, 2'b00);
        add(8'b0100_0000, 16'h0,    3'd1, E_NO, 16'h0000, 32'd0, 2'b00);
        add(8'b0100_0000, 16'h0,    3'd1, E_NO, 16'h0000, 32'd0, 2'b00);
        add(8'b0100_0000, 16'h0,    3'd7, E_NO, 16'h0000, 32'd0, 2'b01);
        add(8'b0101_0000, 16'h0,    3'd7, E_NO, 16'h0000, 32'd0, 2'b01);
        // if_done in 4th IF cycle is accepted
        add(8'b1000_0000, 16'h0,    3'd0, E_NO, 16'h0000, 32'd0, 2'b00);
        add(8'b0100_0000, 16'h0,    3'd1, E_IF, 16'h0000, 32'd0, 2'b00);
        add(8'b0100_0000, 16'h0,    3'd1, E_NO, 16'h0000, 32'd0, 2'b00);
        add(8'b0100_0000, 16'h0,    3'd1, E_NO, 16'h0000, 32'd0, 2'b00);
        add(8'b0100_0000, 16'h0,    3'd1, E_NO, 16'h0000, 32'd0, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd2, E_ID, 16'h0000, 32'd0, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd3, E_EX, 16'h0000, 32'd0, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd5, E_WB, 16'h0000, 32'd0, 2'b00);
        add(8'b0100_0000, 16'h0,    3'd1, E_IF, 16'h0001, 32'd1, 2'b00);
        // rst during the IF wait, then normal re-run
        add(8'b0100_0000, 16'h0,    3'd1, E_NO, 16'h0001, 32'd1, 2'b00);
        add(8'b1101_0000, 16'h0,    3'd0, E_NO, 16'h0000, 32'd0, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd1, E_IF, 16'h0000, 32'd0, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd2, E_ID, 16'h0000, 32'd0, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd3, E_EX, 16'h0000, 32'd0, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd5, E_WB, 16'h0000, 32'd0, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd1, E_IF, 16'h0001, 32'd1, 2'b00);
        // run low parks in IDLE after WB; raising run gives IF next cycle
        add(8'b0101_0000, 16'h0,    3'd2, E_ID, 16'h0001, 32'd1, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd3, E_EX, 16'h0001, 32'd1, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd5, E_WB, 16'h0001, 32'd1, 2'b00);
        add(8'b0001_0000, 16'h0,    3'd0, E_NO, 16'h0002, 32'd2, 2'b00);
        add(8'b0001_0000, 16'h0,    3'd0, E_NO, 16'h0002, 32'd2, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd1, E_IF, 16'h0002, 32'd2, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd2, E_ID, 16'h0002, 32'd2, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd3, E_EX, 16'h0002, 32'd2, 2'b00);
        add(8'b0101_0000, 16'h0,    3'd5, E_WB, 16'h0002, 32'd2, 2'b00);
        add(8'b0001_0000, 16'h0,    3'd0, E_NO, 16'h0003, 32'd3, 2'b00);
        // halt_req beats run in IDLE
        add(8'b0111_0000, 16'h0,    3'd6, E_NO, 16'h0003, 32'd3, 2'b10);

        foreach (vecs[i]) begin
            {rst, run, halt_req, if_done, inst_is_mem, inst_is_halt, br_taken, mem_done} = vecs[i].ctl;
            br_target = vecs[i].bra;
            sb_q.push_back(vecs[i]);
            tick();
            e = sb_q.pop_front();
            check_vec($sformatf("row%0d", i), e);
        end

        // Random wait lengths within the watchdog window; each instruction must
        // land back in IF with pc/retired advanced after exactly the driven cycles.
        {rst, run, halt_req, if_done, inst_is_mem, inst_is_halt, br_taken, mem_done} = 8'h80;
        tick();
        rst = 1'b0; run = 1'b1;
        tick();
        exp_pc = 16'h0000;
        for (int k = 0; k < 8; k++) begin
            d_if  = int'($urandom_range(0, 3));
            d_mem = int'($urandom_range(0, 3));
            m     = int'($urandom_range(0, 1));
            if_done = 1'b0;
            repeat (d_if) tick();
            if_done = 1'b1;
            tick();
            if_done = 1'b0;
            inst_is_mem = m[0];
            tick();
            inst_is_mem = 1'b0;
            tick();
            if (m != 0) begin
                repeat (d_mem) tick();
                mem_done = 1'b1;
                tick();
                mem_done = 1'b0;
            end
            exp_pc = exp_pc + 16'h1;
            e.ctl = 8'h0; e.bra = 16'h0; e.st = 3'd1; e.en = E_IF;
            e.pc = exp_pc; e.ret = 32'(k + 1); e.fl = 2'b00;
            sb_q.push_back(e);
            tick();
            e = sb_q.pop_front();
            check_vec($sformatf("rnd%0d(if+%0d mem%0d+%0d)", k, d_if, m, d_mem), e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/candy_stage_ctrl.md
# candy_stage_ctrl

Parametrised multi-cycle stage sequencer for the candy core. It replaces the fixed four-phase IF/ID/LOAD/WB rotation with a handshake-driven FSM: IF, ID, EX, MEM and WB are sequenced, and the variable-latency stages (IF, MEM) are stalled on done signals. The block owns the program counter and branch redirect, and adds halt, a watchdog timeout and a retired-instruction counter. It sits at the top of the core and drives the enables of the pc, if, id, alu, sram and wb blocks.

## Interface
- ADDR_W, 16, width of pc and br_target
- RESET_PC, 0, pc value after reset
- PC_STEP, 1, pc increment per sequential instruction
- WAIT_MAX, 15, max cycles IF/MEM may wait for done; 0 disables the watchdog
- CNT_W, 32, width of retired counter
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- run  in  1  level; permits leaving IDLE and continuing after WB
- halt_req  in  1  pulse or level; request to stop at next instruction boundary
- if_en  out  1  fetch enable pulse
- if_done  in  1  fetched instruction valid
- id_en  out  1  decode enable pulse
- inst_is_mem  in  1  decoded instruction uses memory, sampled in ID
- inst_is_halt  in  1  decoded halt instruction, sampled in ID
- ex_en  out  1  execute enable pulse
- br_taken  in  1  branch taken, sampled in EX
- br_target  in  ADDR_W  branch target, sampled in EX
- mem_en  out  1  memory-stage enable pulse
- mem_done  in  1  memory access complete
- wb_en  out  1  writeback enable pulse
- pc  out  ADDR_W  current instruction address
- state  out  3  encoded FSM state
- halted  out  1  sticky, core halted
- timeout_err  out  1  sticky, watchdog fired
- retired  out  CNT_W  count of completed WB cycles

## Operation
- State encoding: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6, ERR=7.
- Reset values: state IDLE, pc RESET_PC, all *_en 0, halted 0, timeout_err 0, retired 0, halt-pending 0, mem flag 0, next_pc RESET_PC.
- Each enable output is registered. It is 1 only in the first cycle the FSM spends in its state.
- IDLE:
  - If halt-pending or halt_req is set, go to HALT (halt has priority over run).
  - Otherwise, if run is high, go to IF.
  - Otherwise stay in IDLE.
- IF: wait for if_done. Done is accepted in any cycle in the state, including the first. On done, go to ID.
- ID: one cycle. Latch inst_is_mem into the mem flag.
  - If inst_is_halt is set, go to HALT. pc is not advanced and retired is not incremented.
  - Otherwise go to EX.
- EX: one cycle.
  - next_pc = br_taken ? br_target : pc + PC_STEP, computed modulo 2^ADDR_W.
  - Go to MEM if the mem flag is set, else go to WB.
- MEM: wait for mem_done, with the same acceptance rule as IF. On done, go to WB.
- WB: one cycle.
  - pc <= next_pc; retired <= retired + 1, wrapping at 2^CNT_W.
  - Next state: HALT if halt-pending or halt_req; else IF if run; else IDLE.
- halt_req is latched into halt-pending in any state. It is honoured only in IDLE or at WB exit, so it never aborts an instruction in flight.
- HALT: halted=1, all enables 0, sticky until rst.
- Watchdog (IF and MEM, when WAIT_MAX>0):
  - A wait counter clears on state entry and increments each cycle without done.
  - If done has not been seen by the end of cycle WAIT_MAX in the state, go to ERR.
  - If done arrives in the same cycle as expiry, done wins.
- ERR: timeout_err=1, all enables 0, sticky until rst. pc holds the faulting address.
- rst asserted in any state, including mid-wait, returns every register to its reset value on the next edge. Pending done inputs are ignored.

## Timing
- Instruction latency (IF entry to IF re-entry), done in first cycle: 4 cycles non-mem, 5 cycles mem. Each extra wait cycle adds 1.
- pc changes only on the clock edge leaving WB. It is stable throughout IF..WB of an instruction.
- With run held low, the FSM parks in IDLE after WB. Raising run gives IF on the next cycle.
- With WAIT_MAX=N, the last cycle in which done is accepted is the Nth cycle in the state. ERR is visible on the following cycle.

## Test plan
- Reset, run=1, if_done always 1, non-mem, no branch, PC_STEP=1: state sequence 1,2,3,5,1,... Each if_en/id_en/ex_en/wb_en is a single-cycle pulse. pc goes 0,1,2 and retired goes 0,1,2 on consecutive WB exits.
- Mem instruction, mem_done delayed 3 cycles: MEM lasts 4 cycles, mem_en pulses only in the first, and the instruction takes 8 cycles.
- Branch in EX with br_target=0x0040: pc becomes 0x0040 after WB. Also, with ADDR_W=4 and pc=0xF sequential, pc wraps to 0x0.
- halt_req pulsed during MEM: the instruction completes, retired increments, then HALT with halted=1 and pc advanced. Separately, inst_is_halt in ID gives HALT with no pc or retired change.
- WAIT_MAX=4, if_done never asserted: ERR on the 5th cycle after IF entry, timeout_err=1, pc unchanged. A second run with if_done in the 4th cycle gives ID, not ERR.
- rst asserted during the IF wait: next cycle state=0, pc=RESET_PC, all outputs at reset values. Re-run executes normally.
